// File: rtl/serial_word_packer_if.sv
// Bit-stream input and packed-word valid/ready output of the serial word packer.
interface serial_word_packer_if #(
    parameter int unsigned WIDTH = 8
);
    localparam int unsigned LENW = $clog2(WIDTH + 1);

    logic             bit_in;
    logic             bit_valid;
    logic             flush;
    logic             word_ready;
    logic [WIDTH-1:0] word_out;
    logic [LENW-1:0]  word_len;
    logic             word_valid;
    logic             overflow;

    // Bit source and word sink side.
    modport master (
        output bit_in, bit_valid, flush, word_ready,
        input  word_out, word_len, word_valid, overflow
    );

    // Packer side.
    modport slave (
        input  bit_in, bit_valid, flush, word_ready,
        output word_out, word_len, word_valid, overflow
    );
endinterface

// File: rtl/serial_word_packer.sv
// Packs qualified serial bits LSB-first into WIDTH-bit words held in a one-word
// valid/ready output slot, with partial-word flush and a sticky drop flag.
module serial_word_packer #(
    parameter int unsigned WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    serial_word_packer_if.slave  bus
);
    localparam int unsigned LENW = $clog2(WIDTH + 1);

    typedef enum logic [0:0] {EMPTY, FILL} state_t;

    state_t           state, state_n;
    logic [WIDTH-1:0] shreg, shreg_n;
    logic [LENW-1:0]  cnt, cnt_n;
    logic [WIDTH-1:0] word_out_q, word_out_n;
    logic [LENW-1:0]  word_len_q, word_len_n;
    logic             word_valid_q, word_valid_n;
    logic             overflow_q, overflow_n;

    logic [WIDTH-1:0] merged;
    logic [LENW-1:0]  cnt_after;
    logic             emit;
    logic             slot_free;

    // State and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= EMPTY;
            shreg        <= '0;
            cnt          <= '0;
            word_out_q   <= '0;
            word_len_q   <= '0;
            word_valid_q <= 1'b0;
            overflow_q   <= 1'b0;
        end else begin
            state        <= state_n;
            shreg        <= shreg_n;
            cnt          <= cnt_n;
            word_out_q   <= word_out_n;
            word_len_q   <= word_len_n;
            word_valid_q <= word_valid_n;
            overflow_q   <= overflow_n;
        end
    end

    // Next-state, collector and output slot logic.
    always_comb begin
        state_n      = state;
        shreg_n      = shreg;
        cnt_n        = cnt;
        word_out_n   = word_out_q;
        word_len_n   = word_len_q;
        word_valid_n = word_valid_q;
        overflow_n   = overflow_q;

        // Bits above cnt are always zero, so OR-ing in the new bit is enough.
        merged    = shreg | (WIDTH'(bus.bit_in & bus.bit_valid) << cnt);
        cnt_after = cnt + LENW'(bus.bit_valid);
        // A full word and a flushed partial both emit cnt_after bits.
        emit      = (cnt_after == LENW'(WIDTH)) ||
                    (bus.flush && (cnt_after != '0));
        slot_free = !word_valid_q || bus.word_ready;

        if (word_valid_q && bus.word_ready) begin
            word_valid_n = 1'b0;
        end

        if (emit) begin
            if (slot_free) begin
                word_out_n   = merged;
                word_len_n   = cnt_after;
                word_valid_n = 1'b1;
            end else begin
                overflow_n = 1'b1;
            end
        end

        case (state)
            EMPTY: begin
                if (emit) begin
                    shreg_n = '0;
                    cnt_n   = '0;
                end else if (bus.bit_valid) begin
                    shreg_n = merged;
                    cnt_n   = cnt_after;
                    state_n = FILL;
                end
            end
            FILL: begin
                if (emit) begin
                    shreg_n = '0;
                    cnt_n   = '0;
                    state_n = EMPTY;
                end else begin
                    shreg_n = merged;
                    cnt_n   = cnt_after;
                end
            end
            default: begin
                shreg_n = '0;
                cnt_n   = '0;
                state_n = EMPTY;
            end
        endcase
    end

    assign bus.word_out   = word_out_q;
    assign bus.word_len   = word_len_q;
    assign bus.word_valid = word_valid_q;
    assign bus.overflow   = overflow_q;
endmodule

// File: tb/tb_serial_word_packer.sv
// Directed vector bench for serial_word_packer (WIDTH=8): one table-driven run of
// per-cycle vectors plus hand-written reset, flush and same-edge sequences.
module tb_serial_word_packer;
    localparam int unsigned WIDTH = 8;
    localparam int unsigned LENW  = $clog2(WIDTH + 1);

    logic clk;
    logic rst;

    serial_word_packer_if #(.WIDTH(WIDTH)) bus ();

    serial_word_packer #(.WIDTH(WIDTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic             bi;
        logic             bv;
        logic             fl;
        logic             rdy;
        logic [WIDTH-1:0] eo;
        logic [LENW-1:0]  el;
        logic             ev;
        logic             eov;
    } vec_t;

    vec_t vecs[$];
    int   passed;
    int   total;

    function automatic void add(input logic bi, input logic bv, input logic fl,
                                input logic rdy, input logic [WIDTH-1:0] eo,
                                input logic [LENW-1:0] el, input logic ev,
                                input logic eov);
        vec_t v;
        v.bi = bi; v.bv = bv; v.fl = fl; v.rdy = rdy;
        v.eo = eo; v.el = el; v.ev = ev; v.eov = eov;
        vecs.push_back(v);
    endfunction

    task automatic check(input string name, input logic [WIDTH-1:0] eo,
                         input logic [LENW-1:0] el, input logic ev, input logic eov);
        total++;
        if (bus.word_out === eo && bus.word_len === el &&
            bus.word_valid === ev && bus.overflow === eov) begin
            passed++;
        end else begin
            $display("FAIL %s: got out=%h len=%0d valid=%b ovf=%b, want out=%h len=%0d valid=%b ovf=%b",
                     name, bus.word_out, bus.word_len, bus.word_valid, bus.overflow,
                     eo, el, ev, eov);
        end
    endtask

    // Drive at negedge, clock once, compare registered outputs 1 ns after the edge.
    task automatic step(input string name, input logic bi, input logic bv,
                        input logic fl, input logic rdy, input logic [WIDTH-1:0] eo,
                        input logic [LENW-1:0] el, input logic ev, input logic eov);
        @(negedge clk);
        bus.bit_in     = bi;
        bus.bit_valid  = bv;
        bus.flush      = fl;
        bus.word_ready = rdy;
        @(posedge clk);
        #1;
        check(name, eo, el, ev, eov);
    endtask

    // Feed bits 0..6 of w while the output is expected to hold (po, pl, pv, pov).
    task automatic feed7(input string name, input logic [WIDTH-1:0] w, input logic rdy,
                         input logic [WIDTH-1:0] po, input logic [LENW-1:0] pl,
                         input logic pv, input logic pov);
        for (int i = 0; i < 7; i++) begin
            step(name, w[i], 1'b1, 1'b0, rdy, po, pl, pv, pov);
        end
    endtask

    initial begin
        logic [WIDTH-1:0] w;
        passed = 0;
        total  = 0;
        bus.bit_in = 1'b0; bus.bit_valid = 1'b0; bus.flush = 1'b0; bus.word_ready = 1'b0;
        rst = 1'b1;
        #1;
        check("reset_state", 8'h00, 4'd0, 1'b0, 1'b0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Single word 1,0,1,1,0,0,1,0 -> 8'h4D, valid for exactly one cycle.
        add(1, 1, 0, 1, 8'h00, 4'd0, 0, 0);
        add(0, 1, 0, 1, 8'h00, 4'd0, 0, 0);
        add(1, 1, 0, 1, 8'h00, 4'd0, 0, 0);
        add(1, 1, 0, 1, 8'h00, 4'd0, 0, 0);
        add(0, 1, 0, 1, 8'h00, 4'd0, 0, 0);
        add(0, 1, 0, 1, 8'h00, 4'd0, 0, 0);
        add(1, 1, 0, 1, 8'h00, 4'd0, 0, 0);
        add(0, 1, 0, 1, 8'h4D, 4'd8, 1, 0);
        add(0, 0, 0, 1, 8'h4D, 4'd8, 0, 0);

        // Gapped: 8'hA5 then 8'h3C, bit_in=1 on every unqualified cycle.
        w = 8'hA5;
        for (int i = 0; i < 7; i++) begin
            add(w[i], 1, 0, 1, 8'h4D, 4'd8, 0, 0);
            add(1,    0, 0, 1, 8'h4D, 4'd8, 0, 0);
        end
        add(w[7], 1, 0, 1, 8'hA5, 4'd8, 1, 0);
        add(1,    0, 0, 1, 8'hA5, 4'd8, 0, 0);
        w = 8'h3C;
        for (int i = 0; i < 7; i++) begin
            add(w[i], 1, 0, 1, 8'hA5, 4'd8, 0, 0);
            add(1,    0, 0, 1, 8'hA5, 4'd8, 0, 0);
        end
        add(w[7], 1, 0, 1, 8'h3C, 4'd8, 1, 0);
        add(1,    0, 0, 1, 8'h3C, 4'd8, 0, 0);

        // Backpressure: A=8'hF0 held, B=8'h0F dropped, then A accepted.
        w = 8'hF0;
        for (int i = 0; i < 7; i++) add(w[i], 1, 0, 0, 8'h3C, 4'd8, 0, 0);
        add(w[7], 1, 0, 0, 8'hF0, 4'd8, 1, 0);
        w = 8'h0F;
        for (int i = 0; i < 7; i++) add(w[i], 1, 0, 0, 8'hF0, 4'd8, 1, 0);
        add(w[7], 1, 0, 0, 8'hF0, 4'd8, 1, 1);
        add(0,    0, 0, 1, 8'hF0, 4'd8, 0, 1);

        // Flush partial 1,1,0 -> 8'h03 len 3; empty flush is a no-op.
        add(1, 1, 0, 1, 8'hF0, 4'd8, 0, 1);
        add(1, 1, 0, 1, 8'hF0, 4'd8, 0, 1);
        add(0, 1, 0, 1, 8'hF0, 4'd8, 0, 1);
        add(0, 0, 1, 1, 8'h03, 4'd3, 1, 1);
        add(0, 0, 0, 1, 8'h03, 4'd3, 0, 1);
        add(0, 0, 1, 1, 8'h03, 4'd3, 0, 1);
        add(0, 0, 0, 1, 8'h03, 4'd3, 0, 1);
        // Flush on a sampling edge includes that bit: 0,1,+1 -> 8'h06 len 3.
        add(0, 1, 0, 1, 8'h03, 4'd3, 0, 1);
        add(1, 1, 0, 1, 8'h03, 4'd3, 0, 1);
        add(1, 1, 1, 1, 8'h06, 4'd3, 1, 1);
        add(0, 0, 0, 1, 8'h06, 4'd3, 0, 1);

        foreach (vecs[i]) begin
            step($sformatf("vec%0d", i), vecs[i].bi, vecs[i].bv, vecs[i].fl, vecs[i].rdy,
                 vecs[i].eo, vecs[i].el, vecs[i].ev, vecs[i].eov);
        end

        // Async reset mid-word after 3 bits, then a full word must start at bit 0.
        step("pre_rst_b0", 1, 1, 0, 1, 8'h06, 4'd3, 0, 1);
        step("pre_rst_b1", 1, 1, 0, 1, 8'h06, 4'd3, 0, 1);
        step("pre_rst_b2", 1, 1, 0, 1, 8'h06, 4'd3, 0, 1);
        #2;
        rst = 1'b1;
        #1;
        check("async_reset", 8'h00, 4'd0, 1'b0, 1'b0);
        @(negedge clk);
        bus.bit_valid = 1'b0;
        rst = 1'b0;
        feed7("post_rst_fill", 8'h81, 1'b1, 8'h00, 4'd0, 1'b0, 1'b0);
        step("post_rst_word", 1, 1, 0, 1, 8'h81, 4'd8, 1, 0);
        step("post_rst_drain", 0, 0, 0, 1, 8'h81, 4'd8, 0, 0);

        // Flush on the 8th-bit edge: one full word, no extra partial.
        feed7("flush8_fill", 8'h55, 1'b1, 8'h81, 4'd8, 1'b0, 1'b0);
        step("flush8_word", 0, 1, 1, 1, 8'h55, 4'd8, 1, 0);
        step("flush8_drain", 0, 0, 0, 1, 8'h55, 4'd8, 0, 0);
        step("flush8_no_extra", 0, 0, 0, 1, 8'h55, 4'd8, 0, 0);

        // Drain and load on the same edge: no bubble, no overflow.
        feed7("same_edge_a", 8'h12, 1'b0, 8'h55, 4'd8, 1'b0, 1'b0);
        step("same_edge_a_word", 0, 1, 0, 0, 8'h12, 4'd8, 1, 0);
        feed7("same_edge_hold", 8'h34, 1'b0, 8'h12, 4'd8, 1'b1, 1'b0);
        step("same_edge_b_word", 0, 1, 0, 1, 8'h34, 4'd8, 1, 0);
        step("same_edge_drain", 0, 0, 0, 1, 8'h34, 4'd8, 0, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    // Safety bound so the run always ends.
    initial begin
        #200000;
        $display("FAIL timeout: got no end of test, want finish before 200000 ns");
        $fatal(1);
    end
endmodule
